regfile_wb_writer: RTL

//  Writeback-stage producer for the integer register file write port (reg_wrMW/waddr_MW/wdata).

---
 rtl/regfile_wb_writer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_writer.sv
// Writeback-stage producer for the integer register file write port.
// Selects ALU/PC+4/CSR results directly and waits on variable-latency loads with a timeout watchdog.
module regfile_wb_writer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_reg_wr,
   input  logic [4:0]  ex_rd,
   input  logic [1:0]  ex_wb_sel,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_pc_plus4,
   input  logic [31:0] ex_csr_rdata,
   input  logic [2:0]  ex_funct3,
   input  logic        flush,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        reg_wrMW,
   output logic [4:0]  waddr_MW,
   output logic [31:0] wdata,
   output logic        stall,
   output logic        load_fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_LOAD = 2'd1;
   localparam logic [1:0] SEL_PC4  = 2'd2;
   localparam logic [1:0] SEL_CSR  = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Context of the outstanding load, captured when it leaves execute.
   logic [4:0]       ld_rd;
   logic             ld_reg_wr;
   logic [2:0]       ld_funct3;
   logic [1:0]       ld_addr;

   logic [31:0]      direct_data;
   logic [31:0]      load_data;
   logic             accept;
   logic             accept_load;

   // Extracts the addressed byte/half from the returned word and extends it.
   function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                              input logic [1:0]  addr,
                                              input logic [31:0] word);
      logic [7:0]  byte_lane;
      logic [15:0] half_lane;
      logic [31:0] result;
      case (addr)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      half_lane = addr[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   result = {{16{half_lane[15]}}, half_lane};
         F3_LBU:  result = {24'd0, byte_lane};
         F3_LHU:  result = {16'd0, half_lane};
         default: result = word;
      endcase
      return result;
   endfunction

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      direct_data = ex_alu_result;
      case (ex_wb_sel)
         SEL_PC4: direct_data = ex_pc_plus4;
         SEL_CSR: direct_data = ex_csr_rdata;
         default: direct_data = ex_alu_result;
      endcase
   end

   assign load_data   = align_load(ld_funct3, ld_addr, dmem_rdata);
   assign accept      = ex_valid && !flush;
   assign accept_load = accept && (ex_wb_sel == SEL_LOAD);

   // Stall follows state directly, so it stays high in the cycle rvalid is sampled.
   assign stall = (state == WAIT_LOAD);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         reg_wrMW   <= 1'b0;
         waddr_MW   <= 5'd0;
         wdata      <= 32'd0;
         load_fault <= 1'b0;
      end else begin
         reg_wrMW   <= 1'b0;
         load_fault <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept_load) begin
                  state <= WAIT_LOAD;
               end else if (accept) begin
                  reg_wrMW <= ex_reg_wr && (ex_rd != 5'd0);
                  waddr_MW <= ex_rd;
                  wdata    <= direct_data;
               end
            end
            WAIT_LOAD: begin
               if (flush) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (dmem_rvalid) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  reg_wrMW <= ld_reg_wr && (ld_rd != 5'd0);
                  waddr_MW <= ld_rd;
                  wdata    <= load_data;
               end else if (cnt == CNT_LAST) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  load_fault <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // NOTE: load context is pure datapath, only read after being captured, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && accept_load) begin
         ld_rd     <= ex_rd;
         ld_reg_wr <= ex_reg_wr;
         ld_funct3 <= ex_funct3;
         ld_addr   <= ex_alu_result[1:0];
      end
   end

endmodule
